// File: rtl/pipe_sel_reg.sv
// N-way operand selector latched into a pipeline register, with stall/flush, valid bit and out-of-range error counting.
// Latency: one cycle from src_bus/sel to out_data; no combinational path from inputs to outputs.
// Backpressure: stall holds every register including err_cnt; flush overrides stall and inserts a bubble.
module pipe_sel_reg #(
    parameter int WIDTH       = 32,
    parameter int NSRC        = 4,
    parameter int SELW        = 2,
    parameter int DEFAULT_SRC = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC*WIDTH-1:0]   src_bus,
    input  logic [SELW-1:0]         sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SELW-1:0]         out_sel,
    output logic                    sel_err,
    output logic [15:0]             err_cnt
);

    if (NSRC < 2 || NSRC > 16) begin : g_bad_nsrc
        $error("pipe_sel_reg: NSRC must be in 2..16");
    end
    if ((2 ** SELW) < NSRC) begin : g_bad_selw
        $error("pipe_sel_reg: SELW too narrow for NSRC");
    end
    if (DEFAULT_SRC < 0 || DEFAULT_SRC >= NSRC) begin : g_bad_default
        $error("pipe_sel_reg: DEFAULT_SRC must be below NSRC");
    end

    // One extra bit so NSRC == 2**SELW is representable; the compare then folds to constant false.
    localparam logic [SELW:0]   NSRC_W  = (SELW+1)'(NSRC);
    localparam logic [SELW-1:0] DEF_SEL = SELW'(DEFAULT_SRC);

    logic             sel_oor;
    logic [SELW-1:0]  eff_sel;
    logic [WIDTH-1:0] data_mux;
    logic             set_err;

    always_comb begin
        sel_oor  = ({1'b0, sel} >= NSRC_W);
        eff_sel  = sel_oor ? DEF_SEL : sel;
        set_err  = sel_oor && in_valid;
        data_mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (eff_sel == SELW'(i)) begin
                data_mux = src_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
            err_cnt   <= '0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else if (!stall) begin
            out_data  <= data_mux;
            out_valid <= in_valid;
            out_sel   <= eff_sel;
            sel_err   <= set_err;
            // Saturate rather than wrap so a long error burst never reads back as clean.
            if (set_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Directed bench for pipe_sel_reg: a full 4-source instance and a 3-source instance with an out-of-range select code.
module tb_pipe_sel_reg;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NSRC = 2**SELW, out-of-range path unreachable.
    logic [127:0] src_a = '0;
    logic [1:0]   sel_a = '0;
    logic         iv_a = 1'b0, stall_a = 1'b0, flush_a = 1'b0;
    logic [31:0]  data_a;
    logic         valid_a, err_a;
    logic [1:0]   osel_a;
    logic [15:0]  cnt_a;

    // Instance B: NSRC = 3, sel = 3 is out of range and maps to source 1.
    logic [95:0]  src_b = '0;
    logic [1:0]   sel_b = '0;
    logic         iv_b = 1'b0, stall_b = 1'b0, flush_b = 1'b0;
    logic [31:0]  data_b;
    logic         valid_b, err_b;
    logic [1:0]   osel_b;
    logic [15:0]  cnt_b;

    pipe_sel_reg #(.WIDTH(32), .NSRC(4), .SELW(2), .DEFAULT_SRC(0)) dut_a (
        .clk(clk), .reset(reset), .src_bus(src_a), .sel(sel_a), .in_valid(iv_a),
        .stall(stall_a), .flush(flush_a), .out_data(data_a), .out_valid(valid_a),
        .out_sel(osel_a), .sel_err(err_a), .err_cnt(cnt_a)
    );

    pipe_sel_reg #(.WIDTH(32), .NSRC(3), .SELW(2), .DEFAULT_SRC(1)) dut_b (
        .clk(clk), .reset(reset), .src_bus(src_b), .sel(sel_b), .in_valid(iv_b),
        .stall(stall_b), .flush(flush_b), .out_data(data_b), .out_valid(valid_b),
        .out_sel(osel_b), .sel_err(err_b), .err_cnt(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (data_a !== 32'h0 || valid_a !== 1'b0 || osel_a !== 2'd0 || err_a !== 1'b0 || cnt_a !== 16'h0) begin
            errors++; $display("FAIL reset_a: got data=%h v=%b sel=%0d err=%b cnt=%h, expected all zero", data_a, valid_a, osel_a, err_a, cnt_a);
        end
        checks++; if (data_b !== 32'h0 || valid_b !== 1'b0 || osel_b !== 2'd0 || err_b !== 1'b0 || cnt_b !== 16'h0) begin
            errors++; $display("FAIL reset_b: got data=%h v=%b sel=%0d err=%b cnt=%h, expected all zero", data_b, valid_b, osel_b, err_b, cnt_b);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load();
        src_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel_a = 2'd2; iv_a = 1'b1;
        tick();
        checks++; if (data_a !== 32'h33333333) begin errors++; $display("FAIL load_data: got %h expected 33333333", data_a); end
        checks++; if (valid_a !== 1'b1 || osel_a !== 2'd2 || err_a !== 1'b0) begin
            errors++; $display("FAIL load_flags: got v=%b sel=%0d err=%b expected v=1 sel=2 err=0", valid_a, osel_a, err_a);
        end
        sel_a = 2'd0; iv_a = 1'b0;
        tick();
        checks++; if (data_a !== 32'h11111111 || valid_a !== 1'b0 || osel_a !== 2'd0) begin
            errors++; $display("FAIL invalid_load: got data=%h v=%b sel=%0d expected 11111111 v=0 sel=0", data_a, valid_a, osel_a);
        end
        sel_a = 2'd3; iv_a = 1'b1;
        tick();
        checks++; if (data_a !== 32'h44444444 || osel_a !== 2'd3 || err_a !== 1'b0 || cnt_a !== 16'h0) begin
            errors++; $display("FAIL full_range_sel3: got data=%h sel=%0d err=%b cnt=%h expected 44444444 sel=3 err=0 cnt=0", data_a, osel_a, err_a, cnt_a);
        end
    endtask

    task automatic test_out_of_range();
        src_b = {32'hC0C0C0C0, 32'hB1B1B1B1, 32'hA0A0A0A0};
        sel_b = 2'd3; iv_b = 1'b1;
        tick();
        checks++; if (data_b !== 32'hB1B1B1B1 || osel_b !== 2'd1) begin
            errors++; $display("FAIL oor_default: got data=%h sel=%0d expected B1B1B1B1 sel=1", data_b, osel_b);
        end
        checks++; if (err_b !== 1'b1 || cnt_b !== 16'd1 || valid_b !== 1'b1) begin
            errors++; $display("FAIL oor_err: got err=%b cnt=%h v=%b expected err=1 cnt=1 v=1", err_b, cnt_b, valid_b);
        end
        sel_b = 2'd0;
        tick();
        checks++; if (data_b !== 32'hA0A0A0A0 || err_b !== 1'b0 || cnt_b !== 16'd1) begin
            errors++; $display("FAIL oor_recover: got data=%h err=%b cnt=%h expected A0A0A0A0 err=0 cnt=1", data_b, err_b, cnt_b);
        end
    endtask

    task automatic test_stall();
        src_a = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        sel_a = 2'd1; iv_a = 1'b1;
        tick();
        checks++; if (data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_preload: got %h expected DEADBEEF", data_a); end
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_a = {4{32'h01010101 * (i + 1)}};
            sel_a = 2'(i);
            iv_a  = i[0];
            tick();
            checks++; if (data_a !== 32'hDEADBEEF || valid_a !== 1'b1 || osel_a !== 2'd1) begin
                errors++; $display("FAIL stall_hold%0d: got data=%h v=%b sel=%0d expected DEADBEEF v=1 sel=1", i, data_a, valid_a, osel_a);
            end
        end
        stall_a = 1'b0;
        src_a = {32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
        sel_a = 2'd0; iv_a = 1'b1;
        #2;
        checks++; if (data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL no_comb_path: got %h expected DEADBEEF", data_a); end
        tick();
        checks++; if (data_a !== 32'hCAFEF00D || osel_a !== 2'd0) begin
            errors++; $display("FAIL stall_release: got data=%h sel=%0d expected CAFEF00D sel=0", data_a, osel_a);
        end
    endtask

    task automatic test_flush_vs_stall();
        sel_b = 2'd3; iv_b = 1'b1;
        tick();
        checks++; if (valid_b !== 1'b1 || err_b !== 1'b1 || cnt_b !== 16'd2) begin
            errors++; $display("FAIL flush_preload: got v=%b err=%b cnt=%h expected v=1 err=1 cnt=2", valid_b, err_b, cnt_b);
        end
        flush_b = 1'b1; stall_b = 1'b1;
        tick();
        checks++; if (data_b !== 32'h0 || valid_b !== 1'b0 || osel_b !== 2'd0 || err_b !== 1'b0) begin
            errors++; $display("FAIL flush_over_stall: got data=%h v=%b sel=%0d err=%b expected all zero", data_b, valid_b, osel_b, err_b);
        end
        checks++; if (cnt_b !== 16'd2) begin errors++; $display("FAIL flush_cnt: got %h expected 2", cnt_b); end
        flush_b = 1'b0; stall_b = 1'b0;
    endtask

    task automatic test_async_reset();
        sel_b = 2'd3; iv_b = 1'b1;
        repeat (3) tick();
        checks++; if (cnt_b !== 16'd5 || valid_b !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got cnt=%h v=%b expected cnt=5 v=1", cnt_b, valid_b);
        end
        stall_b = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (data_b !== 32'h0 || valid_b !== 1'b0 || osel_b !== 2'd0 || err_b !== 1'b0 || cnt_b !== 16'h0) begin
            errors++; $display("FAIL areset_mid: got data=%h v=%b sel=%0d err=%b cnt=%h expected all zero", data_b, valid_b, osel_b, err_b, cnt_b);
        end
        reset = 1'b0;
        tick();
        checks++; if (valid_b !== 1'b0 || cnt_b !== 16'h0 || data_b !== 32'h0) begin
            errors++; $display("FAIL areset_stall_after: got data=%h v=%b cnt=%h expected zero", data_b, valid_b, cnt_b);
        end
        stall_b = 1'b0;
    endtask

    task automatic test_saturation();
        sel_b = 2'd3; iv_b = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (cnt_b !== 16'hFFFE) begin errors++; $display("FAIL sat_edge: got %h expected FFFE", cnt_b); end
        tick();
        checks++; if (cnt_b !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected FFFF", cnt_b); end
        repeat (2) tick();
        checks++; if (cnt_b !== 16'hFFFF || err_b !== 1'b1) begin
            errors++; $display("FAIL sat_hold: got cnt=%h err=%b expected FFFF err=1", cnt_b, err_b);
        end
        iv_b = 1'b0;
        tick();
        checks++; if (err_b !== 1'b0 || cnt_b !== 16'hFFFF || valid_b !== 1'b0 || osel_b !== 2'd1) begin
            errors++; $display("FAIL invalid_oor: got err=%b cnt=%h v=%b sel=%0d expected err=0 cnt=FFFF v=0 sel=1", err_b, cnt_b, valid_b, osel_b);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_out_of_range();
        test_stall();
        test_flush_vs_stall();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_sel_reg.md
Name: pipe_sel_reg

Overview:
- Parametrised N-way operand selector with a registered output.
- Successor to the CPU's fixed 2/3-input 32-bit and 5-bit selectors.
- Used as the select-and-latch point between pipeline stages, for example the forwarding operand select into the E-stage register and write-register select into the M-stage register.
- Adds stall/flush control, a valid bit, defined behaviour for out-of-range selects, and an error counter.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NSRC, 4, number of sources; legal range 2..16.
- SELW, 2, select width. Must satisfy 2^SELW >= NSRC; the implementation checks this at elaboration.
- DEFAULT_SRC, 0, source index used when sel >= NSRC. Must be < NSRC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_bus  input  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SELW  source select.
- in_valid  input  1  current sel/src_bus describe a real instruction.
- stall  input  1  hold all registered state.
- flush  input  1  insert a bubble.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data belongs to a valid instruction.
- out_sel  output  SELW  registered effective select, after DEFAULT_SRC substitution.
- sel_err  output  1  registered flag: the word currently in the register was loaded with an out-of-range sel.
- err_cnt  output  16  saturating count of out-of-range loads.

Behaviour:
- Reset (asynchronous, takes effect immediately, any cycle):
  - out_data = 0, out_valid = 0, out_sel = 0, sel_err = 0, err_cnt = 0.
- Effective select:
  - eff = sel when sel < NSRC, otherwise eff = DEFAULT_SRC.
  - Purely combinational. No case falls through, no latch inferred, so it is well-defined for every sel value.
- Latency: one cycle. A source word sampled at edge k appears on out_data after edge k; there is no combinational path from src_bus to out_data.
- Per-edge priority when reset is low: flush > stall > load.
- flush = 1:
  - out_data = 0, out_valid = 0, out_sel = 0, sel_err = 0.
  - err_cnt unchanged.
  - Flush wins over a simultaneous stall.
- stall = 1 and flush = 0:
  - All outputs hold, including err_cnt.
  - sel and in_valid are ignored for that cycle.
- Load (flush = 0, stall = 0):
  - out_data = src_bus slice[eff], out_sel = eff, out_valid = in_valid.
  - sel_err = (sel >= NSRC) AND in_valid.
  - err_cnt increments by 1 only when sel_err is being set, and saturates at 16'hFFFF with no wrap.
- Invalid loads (in_valid = 0, flush = 0, stall = 0): the data is still loaded, so downstream must qualify it with out_valid. An out-of-range sel on an invalid load neither raises sel_err nor counts.
- When NSRC = 2^SELW, the out-of-range path is unreachable; sel_err and err_cnt stay at 0.
- Reset asserted mid-stall or mid-flush: reset wins immediately. On the first edge after reset deasserts, normal priority applies.
- The design has no other state and no state machine beyond the valid/err registers and the counter.

Test Plan:
- Reset then load (NSRC=4, WIDTH=32): sources 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel=2, in_valid=1 for one edge -> out_data=0x33333333, out_valid=1, out_sel=2, sel_err=0.
- Out-of-range (NSRC=3, SELW=2, DEFAULT_SRC=1): sel=3, in_valid=1, load -> out_data = src1, out_sel=1, sel_err=1, err_cnt=1. The next load with sel=0 -> sel_err=0, err_cnt stays 1.
- Stall hold: load 0xDEADBEEF, then stall=1 for 3 cycles while src/sel change -> out_data stays 0xDEADBEEF and out_valid stays 1. Release stall -> new value appears one edge later.
- Flush vs stall: out_valid=1, assert flush=1 and stall=1 on the same edge -> out_data=0, out_valid=0, sel_err=0, err_cnt unchanged.
- Saturation: force 65537 out-of-range valid loads -> err_cnt=0xFFFF and holds. An out-of-range sel with in_valid=0 -> no increment and sel_err=0.
- Async reset: assert reset mid-cycle between edges while out_valid=1 and err_cnt=5 -> all outputs read 0 before the next clk edge.
